cdb_issue_arbiter: RTL
======================

// Module: cdb_issue_arbiter
// PURPOSE
//  Issue scheduler between the three execution queues (integer, multiply, LD/ST) and the single Common Data Bus.
//  Grants at most one issue per queue per cycle. Each grant reserves the CDB cycle in which that unit's result
//  will appear, so two results never collide on the CDB.
//  Sits after the issue queues that the dispatch unit fills. Drives the CDB source select for the result mux.
// PARAMETERS
//  INT_LAT   1  cycles from integer issue to its CDB cycle (1..MUL_LAT-1)
//  LDST_LAT  1  cycles from LD/ST issue to its CDB cycle (1..MUL_LAT-1)
//  MUL_LAT   4  cycles from multiply issue to its CDB cycle (>=2)
// PORTS
//  clock         in   1  single clock, rising edge
//  reset         in   1  synchronous, active-high
//  flush         in   1  mispredict flush: suppress all grants this cycle
//  int_ready     in   1  integer queue holds an instruction with both operands valid
//  ldst_ready    in   1  LD/ST queue holds a ready instruction
//  mul_ready     in   1  multiply queue holds a ready instruction
//  issue_int     out  1  grant to integer queue (combinational, same cycle)
//  issue_ldst    out  1  grant to LD/ST queue (combinational)
//  issue_mul     out  1  grant to multiply queue (combinational)
//  cdb_valid     out  1  registered: a result drives the CDB this cycle
//  cdb_src       out  2  registered: CDB owner this cycle (CDB_SRC_* codes)
// BEHAVIOUR
//  - Reservation table res[k], k=0..MUL_LAT-1, each entry {v, src[1:0]}; res[k] is the CDB cycle k cycles ahead.
//  - res[0] is the output register: cdb_valid = res[0].v, cdb_src = res[0].src.
//  - Grant rules (cycle t, all gated by !flush && !reset):
//    - issue_mul = mul_ready. Slot t+MUL_LAT is never pre-reserved, so this grant is always legal.
//    - issue_int = int_ready && !res[INT_LAT].v, subject to the tie rule.
//    - issue_ldst = ldst_ready && !res[LDST_LAT].v, subject to the tie rule.
//    - Tie rule: applies when INT_LAT==LDST_LAT and both are eligible. Grant the one that is not rr_last.
//      rr_last then <= the winner. rr_last changes only on a tie.
//    - With INT_LAT!=LDST_LAT, both may be granted in the same cycle.
//  - Update at each edge:
//    - res[k-1] <= res[k] for k=1..MUL_LAT-1.
//    - A grant with latency L writes {1,src} into res[L-1]. The mul grant writes res[MUL_LAT-1].
//    - res[MUL_LAT-1] <= 0 when there is no mul grant.
//  - Latency: a grant in cycle t yields cdb_valid=1 with matching cdb_src in cycle t+L. No other unit is granted
//    into that cycle.
//  - Flush: grants are forced to 0 for that cycle. Existing reservations are kept; older in-flight ops still
//    complete. rr_last is not updated.
//  - Reset (including mid-operation): all res entries, cdb_valid and cdb_src = 0 (CDB_SRC_NONE).
//    rr_last = LDST, so integer wins the first tie. Grants are 0 while reset is high.
//  - Ready held high with no grant: the queue retries next cycle. No grant is ever lost or buffered.
//  - Invariant (assert): at most one writer per res entry per edge. cdb_src!=NONE iff cdb_valid.
// STRUCTURE
//  - Shared include cdb_defs.vh:
//    - CDB_SRC_NONE=2'd0, CDB_SRC_INT=2'd1, CDB_SRC_LDST=2'd2, CDB_SRC_MUL=2'd3.
//    - Default latency constants.
//  - Sub-module cdb_slot_shreg: parameterised depth MUL_LAT. Per-slot write enables and src. Exports the v vector
//    for lookahead. Arbitration and round-robin stay in the top.
// TESTING
//  1. Reset held 3 cycles with all ready=1 -> all issue_*=0, cdb_valid=0, cdb_src=0.
//  2. int_ready=1 only, 5 cycles from t0 -> issue_int=1 t0..t0+4; cdb_src=INT, cdb_valid=1 at t0+1..t0+5.
//  3. int_ready=ldst_ready=1, 6 cycles from reset release -> grants INT,LDST,INT,LDST,INT,LDST.
//     The CDB shows the same sequence one cycle later.
//  4. mul_ready pulse at t0, int_ready=1 continuous -> issue_mul at t0. issue_int=0 only at t0+3.
//     cdb_src=MUL at t0+4, INT in every other cycle.
//  5. mul_ready=1 at t0..t0+3 plus int/ldst ready -> 4 mul grants, cdb_src=MUL t0+4..t0+7.
//     int/ldst are blocked at t0+3..t0+6.
//  6. mul grant at t0, flush at t0+1 with all ready -> no grants at t0+1; cdb_src=MUL still at t0+4.
//     Reset at t0+2 instead -> cdb_valid=0 at t0+4.

Source files
------------

// File: rtl/cdb_issue_arbiter_pkg.sv
// CDB issue arbiter shared definitions.
// Source codes for the CDB result mux and default unit latencies.
package cdb_issue_arbiter_pkg;

  typedef enum logic [1:0] {
    CDB_SRC_NONE = 2'd0,
    CDB_SRC_INT  = 2'd1,
    CDB_SRC_LDST = 2'd2,
    CDB_SRC_MUL  = 2'd3
  } cdb_src_e;

  localparam int DEF_INT_LAT  = 1;
  localparam int DEF_LDST_LAT = 1;
  localparam int DEF_MUL_LAT  = 4;

endpackage

// File: rtl/cdb_issue_arbiter_slot_shreg.sv
// CDB reservation table: slot k is the CDB cycle k cycles ahead.
// Ports: clock/reset, per-slot write enables and sources, v vector, slot 0 source.
module cdb_issue_arbiter_slot_shreg
  import cdb_issue_arbiter_pkg::*;
#(
  parameter int DEPTH = DEF_MUL_LAT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DEPTH-1:0]      i_wr_en,
  input  logic [DEPTH-1:0][1:0] i_wr_src,
  output logic [DEPTH-1:0]      o_v,
  output logic [1:0]            o_src0
);

  logic [DEPTH-1:0]      r_v;
  logic [DEPTH-1:0][1:0] r_src;

  // A write only lands on a slot whose shifted-in
  // neighbour is empty, so write simply overrides shift.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_v   <= '0;
      r_src <= '0;
    end else begin
      for (int k = 0; k < DEPTH-1; k++) begin
        r_v[k]   <= i_wr_en[k] | r_v[k+1];
        r_src[k] <= i_wr_en[k] ? i_wr_src[k]
                                : r_src[k+1];
      end
      r_v[DEPTH-1]   <= i_wr_en[DEPTH-1];
      r_src[DEPTH-1] <= i_wr_en[DEPTH-1]
                        ? i_wr_src[DEPTH-1]
                        : CDB_SRC_NONE;
    end
  end

  assign o_v    = r_v;
  assign o_src0 = r_src[0];

endmodule

// File: rtl/cdb_issue_arbiter.sv
// Issue arbiter for INT, LD/ST and MUL queues sharing one CDB.
// Ports: clock, reset, flush, *_ready in; issue_* grants, cdb_valid/cdb_src out.
module cdb_issue_arbiter
  import cdb_issue_arbiter_pkg::*;
#(
  parameter int INT_LAT  = DEF_INT_LAT,
  parameter int LDST_LAT = DEF_LDST_LAT,
  parameter int MUL_LAT  = DEF_MUL_LAT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       flush,
  input  logic       int_ready,
  input  logic       ldst_ready,
  input  logic       mul_ready,
  output logic       issue_int,
  output logic       issue_ldst,
  output logic       issue_mul,
  output logic       cdb_valid,
  output logic [1:0] cdb_src
);

  logic [MUL_LAT-1:0]      w_v;
  logic [MUL_LAT-1:0]      w_wr_en;
  logic [MUL_LAT-1:0][1:0] w_wr_src;
  logic                    w_gate;
  logic                    w_int_el;
  logic                    w_ldst_el;
  logic                    w_tie;
  cdb_src_e                r_rr_last;

  always_comb begin
    w_gate    = !flush && !reset;
    w_int_el  = w_gate && int_ready
                && !w_v[INT_LAT];
    w_ldst_el = w_gate && ldst_ready
                && !w_v[LDST_LAT];
    // Equal latencies target the same slot.
    w_tie     = (INT_LAT == LDST_LAT)
                && w_int_el && w_ldst_el;
    issue_int  = w_int_el
                 && !(w_tie && r_rr_last == CDB_SRC_INT);
    issue_ldst = w_ldst_el
                 && !(w_tie && r_rr_last == CDB_SRC_LDST);
    issue_mul  = w_gate && mul_ready;
  end

  always_comb begin
    w_wr_en  = '0;
    w_wr_src = '0;
    if (issue_int) begin
      w_wr_en[INT_LAT-1]  = 1'b1;
      w_wr_src[INT_LAT-1] = CDB_SRC_INT;
    end
    if (issue_ldst) begin
      w_wr_en[LDST_LAT-1]  = 1'b1;
      w_wr_src[LDST_LAT-1] = CDB_SRC_LDST;
    end
    if (issue_mul) begin
      w_wr_en[MUL_LAT-1]  = 1'b1;
      w_wr_src[MUL_LAT-1] = CDB_SRC_MUL;
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      r_rr_last <= CDB_SRC_LDST;
    else if (w_tie)
      r_rr_last <= issue_int ? CDB_SRC_INT
                             : CDB_SRC_LDST;
  end

  cdb_issue_arbiter_slot_shreg #(
    .DEPTH (MUL_LAT)
  ) u_res (
    .clock    (clock),
    .reset    (reset),
    .i_wr_en  (w_wr_en),
    .i_wr_src (w_wr_src),
    .o_v      (w_v),
    .o_src0   (cdb_src)
  );

  assign cdb_valid = w_v[0];

  a_one_writer: assert property (
    @(posedge clock) disable iff (reset)
    !(issue_int && issue_ldst
      && INT_LAT == LDST_LAT));

  a_src_valid: assert property (
    @(posedge clock)
    (cdb_src != CDB_SRC_NONE) == cdb_valid);

endmodule
